// File: rtl/ula_16_bits_scheduler_pkg.sv
// rtl/ula_16_bits_scheduler_pkg.sv - shared opcodes, FSM states and datapath width
package ula_ctrl_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_NOT = 3'b100
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOW,
      ST_HIGH,
      ST_DONE
   } state_e;

   // Codes above NOT are illegal and short-circuit to an error response.
   function automatic logic op_is_legal(input logic [2:0] op);
      return op <= OP_NOT;
   endfunction

   // Only add and sub chain a carry/borrow between the two byte passes.
   function automatic logic op_uses_carry(input logic [2:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/ula_16_bits_scheduler_if.sv
// rtl/ula_16_bits_scheduler_if.sv - two requester channels and one response channel
interface ula_16_bits_scheduler_if;

   logic        req0_valid;
   logic        req0_ready;
   logic [2:0]  req0_op;
   logic [15:0] req0_a;
   logic [15:0] req0_b;
   logic        req0_cin;

   logic        req1_valid;
   logic        req1_ready;
   logic [2:0]  req1_op;
   logic [15:0] req1_a;
   logic [15:0] req1_b;
   logic        req1_cin;

   logic        resp_valid;
   logic        resp_ready;
   logic        resp_id;
   logic [15:0] resp_s;
   logic        resp_cout;
   logic        resp_err;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b, req0_cin,
      output req1_valid, req1_op, req1_a, req1_b, req1_cin,
      output resp_ready,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_s, resp_cout, resp_err
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, req0_cin,
      input  req1_valid, req1_op, req1_a, req1_b, req1_cin,
      input  resp_ready,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_s, resp_cout, resp_err
   );

endinterface

// File: rtl/ula_8_bits_structure.sv
// rtl/ula_8_bits_structure.sv - 8-bit ALU slice (add, sub, and, or, not)
module ula_8_bits_structure
   import ula_ctrl_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [3:0]        x_i,
   input  logic              cin_i,
   output logic [DATA_W-1:0] s_o,
   output logic              cout_o
);

   logic [DATA_W:0] sum_w;
   logic [DATA_W:0] diff_w;

   // Byte result; the ninth bit of the wide sum/difference is the carry/borrow.
   always_comb begin
      sum_w  = {1'b0, a_i} + {1'b0, b_i} + {{DATA_W{1'b0}}, cin_i};
      diff_w = {1'b0, a_i} - {1'b0, b_i} - {{DATA_W{1'b0}}, cin_i};
      s_o    = '0;
      cout_o = 1'b0;
      if (!x_i[3]) begin
         case (x_i[2:0])
            OP_ADD: begin
               s_o    = sum_w[DATA_W-1:0];
               cout_o = sum_w[DATA_W];
            end
            OP_SUB: begin
               s_o    = diff_w[DATA_W-1:0];
               cout_o = diff_w[DATA_W];
            end
            OP_AND:  s_o = a_i & b_i;
            OP_OR:   s_o = a_i | b_i;
            OP_NOT:  s_o = ~a_i;
            default: s_o = '0;
         endcase
      end
   end

endmodule

// File: rtl/ula_rr_arbiter_2.sv
// rtl/ula_rr_arbiter_2.sv - two-way round-robin grant with a single priority bit
module ula_rr_arbiter_2 (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [1:0] req_i,
   input  logic       accept_i,
   output logic [1:0] gnt_o
);

   // prio_q = 1 means requester 1 wins a tie.
   logic prio_q;
   logic prio_d;

   // Lone requester always wins; on a tie the one not served last wins.
   always_comb begin
      gnt_o = 2'b00;
      if (req_i[0] && (!req_i[1] || !prio_q)) begin
         gnt_o = 2'b01;
      end else if (req_i[1]) begin
         gnt_o = 2'b10;
      end
   end

   // Hand priority to the other requester after each accept.
   always_comb begin
      prio_d = prio_q;
      if (accept_i) begin
         prio_d = gnt_o[0];
      end
   end

   // Priority register, requester 0 favoured out of reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/ula_16_bits_scheduler.sv
// rtl/ula_16_bits_scheduler.sv - two requesters sharing one 8-bit ALU for 16-bit ops
module ula_16_bits_scheduler
   import ula_ctrl_pkg::*;
(
   input  logic               clk_i,
   input  logic               rst_i,
   ula_16_bits_scheduler_if.slave bus
);

   state_e state_q;
   state_e state_d;

   logic [1:0]          gnt;
   logic                idle;
   logic                accept;
   logic                sel_id;
   logic [2:0]          sel_op;
   logic [15:0]         sel_a;
   logic [15:0]         sel_b;
   logic                sel_cin;

   logic [2:0]          op_q;
   logic [15:0]         a_q;
   logic [15:0]         b_q;
   logic                cin_q;
   logic [DATA_W-1:0]   lo_s_q;
   logic                lo_c_q;

   logic [15:0]         resp_s_q;
   logic                resp_cout_q;
   logic                resp_err_q;
   logic                resp_id_q;

   logic [DATA_W-1:0]   alu_a;
   logic [DATA_W-1:0]   alu_b;
   logic                alu_cin;
   logic [DATA_W-1:0]   alu_s;
   logic                alu_cout;

   ula_rr_arbiter_2 u_arb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .req_i    ({bus.req1_valid, bus.req0_valid}),
      .accept_i (accept),
      .gnt_o    (gnt)
   );

   // Route the granted requester's fields; READY is masked while reset is held.
   always_comb begin
      idle    = (state_q == ST_IDLE) && !rst_i;
      accept  = idle && (gnt != 2'b00);
      sel_id  = gnt[1];
      sel_op  = gnt[1] ? bus.req1_op  : bus.req0_op;
      sel_a   = gnt[1] ? bus.req1_a   : bus.req0_a;
      sel_b   = gnt[1] ? bus.req1_b   : bus.req0_b;
      sel_cin = gnt[1] ? bus.req1_cin : bus.req0_cin;
   end

   assign bus.req0_ready = idle && gnt[0];
   assign bus.req1_ready = idle && gnt[1];
   assign bus.resp_valid = (state_q == ST_DONE);
   assign bus.resp_s     = resp_s_q;
   assign bus.resp_cout  = resp_cout_q;
   assign bus.resp_err   = resp_err_q;
   assign bus.resp_id    = resp_id_q;

   // Next state: legal ops take two byte passes, illegal ops go straight to DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = op_is_legal(sel_op) ? ST_LOW : ST_DONE;
            end
         end
         ST_LOW:  state_d = ST_HIGH;
         ST_HIGH: state_d = ST_DONE;
         ST_DONE: begin
            if (bus.resp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Snapshot the request so later input changes cannot disturb it.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
         cin_q <= 1'b0;
      end else if (accept) begin
         op_q  <= sel_op;
         a_q   <= sel_a;
         b_q   <= sel_b;
         cin_q <= sel_cin;
      end
   end

   // Feed the low byte in LOW and the high byte plus chained carry in HIGH.
   always_comb begin
      alu_a   = a_q[DATA_W-1:0];
      alu_b   = b_q[DATA_W-1:0];
      alu_cin = cin_q;
      if (state_q == ST_HIGH) begin
         alu_a   = a_q[2*DATA_W-1:DATA_W];
         alu_b   = b_q[2*DATA_W-1:DATA_W];
         alu_cin = lo_c_q;
      end
      if (!op_uses_carry(op_q)) begin
         alu_cin = 1'b0;
      end
   end

   ula_8_bits_structure u_alu (
      .a_i    (alu_a),
      .b_i    (alu_b),
      .x_i    ({1'b0, op_q}),
      .cin_i  (alu_cin),
      .s_o    (alu_s),
      .cout_o (alu_cout)
   );

   // Hold the low-pass result until the high pass completes the word.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         lo_s_q <= '0;
         lo_c_q <= 1'b0;
      end else if (state_q == ST_LOW) begin
         lo_s_q <= alu_s;
         lo_c_q <= alu_cout;
      end
   end

   // Response registers: ID/ERR set at accept, data/carry written by the high pass.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         resp_s_q    <= '0;
         resp_cout_q <= 1'b0;
         resp_err_q  <= 1'b0;
         resp_id_q   <= 1'b0;
      end else if (accept) begin
         resp_id_q  <= sel_id;
         resp_err_q <= !op_is_legal(sel_op);
         if (!op_is_legal(sel_op)) begin
            resp_s_q    <= '0;
            resp_cout_q <= 1'b0;
         end
      end else if (state_q == ST_HIGH) begin
         resp_s_q    <= {alu_s, lo_s_q};
         resp_cout_q <= alu_cout;
      end
   end

endmodule
